// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x-oversampled UART receiver with majority voting, false-start
// rejection, optional parity and a valid/ready holding register.
// Ports:
//   clk, rst_n       system clock, synchronous active-low reset
//   rx               asynchronous serial line, idle high
//   rx_ready         downstream accepts the held byte when rx_valid & rx_ready
//   rx_data          received byte (LSB first on the line)
//   rx_valid         rx_data/frame_err/parity_err valid, held until handshake
//   frame_err        stop bit sampled 0 for the held byte
//   parity_err       parity mismatch for the held byte
//   overrun          one-cycle pulse when a completed frame is dropped
//   busy             receiver FSM not idle
module uart_rx_os #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter bit          PARITY_EN  = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned OW       = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [OW-1:0] OS_S0     = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0] OS_S1     = OW'(OVERSAMPLE / 2);
  localparam logic [OW-1:0] OS_DEC    = OW'(OVERSAMPLE / 2 + 1);
  localparam logic [OW-1:0] OS_END    = OW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state, state_nxt;
  logic            rx_meta, rx_s, rx_hist;
  logic [TW-1:0]   tick_cnt;
  logic [OW-1:0]   os_cnt;
  logic [2:0]      bit_cnt;
  logic [1:0]      samp;
  logic [7:0]      shift_reg;
  logic            par_bit;
  logic            done_q, done_ferr, done_perr;

  logic            tick_c, maj_c, dec_c, end_c, start_c;

  assign tick_c  = (state != IDLE) && (tick_cnt == TICK_LAST);
  assign maj_c   = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
  assign dec_c   = tick_c && (os_cnt == OS_DEC);
  assign end_c   = tick_c && (os_cnt == OS_END);
  // Needs a high-to-low transition, so a line stuck low never re-triggers.
  assign start_c = (state == IDLE) && !rx_s && rx_hist;

  // State register; busy tracks the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (start_c) state_nxt = START;
      START: begin
        if (dec_c && maj_c) state_nxt = IDLE;
        else if (end_c)     state_nxt = DATA;
      end
      DATA:   if (end_c && (bit_cnt == 3'd7)) state_nxt = PARITY_EN ? PARITY : STOP;
      PARITY: if (end_c) state_nxt = STOP;
      // Complete at mid-stop so a fast far end can start the next frame early.
      STOP:   if (dec_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Synchronizer, timing counters, sampling and shift datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_hist   <= 1'b0;
      tick_cnt  <= '0;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      samp      <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      done_q    <= 1'b0;
      done_ferr <= 1'b0;
      done_perr <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_hist <= rx_s;

      if ((state == IDLE) || tick_c) tick_cnt <= '0;
      else                           tick_cnt <= tick_cnt + TW'(1);

      if (state == IDLE)     os_cnt <= '0;
      else if (tick_c)       os_cnt <= (os_cnt == OS_END) ? '0 : os_cnt + OW'(1);

      if (state == START)                  bit_cnt <= '0;
      else if ((state == DATA) && end_c)   bit_cnt <= bit_cnt + 3'd1;

      if (tick_c && (os_cnt == OS_S0)) samp[0] <= rx_s;
      if (tick_c && (os_cnt == OS_S1)) samp[1] <= rx_s;

      if ((state == DATA) && dec_c)   shift_reg <= {maj_c, shift_reg[7:1]};
      if ((state == PARITY) && dec_c) par_bit   <= maj_c;

      done_q <= (state == STOP) && dec_c;
      if ((state == STOP) && dec_c) begin
        done_ferr <= ~maj_c;
        done_perr <= PARITY_EN && (par_bit != ((^shift_reg) ^ PARITY_ODD));
      end
    end
  end

  // Holding register with valid/ready handshake and overrun detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done_q) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shift_reg;
          frame_err  <= done_ferr;
          parity_err <= done_perr;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: one 8N1 instance and one even-parity instance.
module tb_uart_rx_os;

  localparam int unsigned BIT = 160;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_a, rx_b, rx_ready, rx_ready_p;
  logic [7:0] rx_data, p_data;
  logic       rx_valid, frame_err, parity_err, overrun, busy;
  logic       p_valid, p_ferr, p_perr, p_ovr, p_busy;

  int n_pass = 0;
  int n_total = 0;
  int ovr_cnt = 0;
  int deliv_cnt = 0;
  int vfall_cnt = 0;
  bit prev_v = 1'b0;
  int base_a, base_b, wn;
  bit ok;

  always #5 clk = ~clk;

  uart_rx_os #(.CLK_FREQ(160), .BAUD(1), .OVERSAMPLE(16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .parity_err(parity_err), .overrun(overrun), .busy(busy));

  uart_rx_os #(.CLK_FREQ(160), .BAUD(1), .OVERSAMPLE(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
    .clk(clk), .rst_n(rst_n), .rx(rx_b), .rx_ready(rx_ready_p),
    .rx_data(p_data), .rx_valid(p_valid), .frame_err(p_ferr),
    .parity_err(p_perr), .overrun(p_ovr), .busy(p_busy));

  // Event counters for the 8N1 instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (overrun) ovr_cnt++;
      if (rx_valid && !prev_v) deliv_cnt++;
      if (!rx_valid && prev_v) vfall_cnt++;
    end
    prev_v = rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  task automatic hold_bit(input bit sel, input logic v, input bit spike);
    drive(sel, v);
    if (spike) begin
      repeat (80) @(negedge clk);
      drive(sel, ~v);
      @(negedge clk);
      drive(sel, v);
      repeat (BIT - 81) @(negedge clk);
    end else begin
      repeat (BIT) @(negedge clk);
    end
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] d, input bit use_par,
                           input logic par, input logic stop, input bit spike0);
    hold_bit(sel, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) hold_bit(sel, d[i], spike0 && (i == 0));
    if (use_par) hold_bit(sel, par, 1'b0);
    hold_bit(sel, stop, 1'b0);
  endtask

  task automatic pulse_ready();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic pulse_ready_p();
    rx_ready_p = 1'b1;
    @(negedge clk);
    rx_ready_p = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; rx_ready = 1'b0; rx_ready_p = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // 1: 0xA5 with a glitch on data bit 0, held then handshaken
    send_byte(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);
    check("t1_valid", rx_valid, 1);
    check("t1_data", rx_data, 8'hA5);
    check("t1_ferr", frame_err, 0);
    check("t1_perr", parity_err, 0);
    repeat (500) @(negedge clk);
    check("t1_held_valid", rx_valid, 1);
    check("t1_held_data", rx_data, 8'hA5);
    pulse_ready();
    check("t1_after_hs", rx_valid, 0);
    repeat (20) @(negedge clk);

    // 2: false start
    base_a = deliv_cnt;
    rx_a = 1'b0;
    repeat (40) @(negedge clk);
    check("t2_busy_rose", busy, 1);
    rx_a = 1'b1;
    wn = 0;
    while (busy && wn < 90) begin @(negedge clk); wn++; end
    ok = !busy;
    check("t2_idle_in_90", ok, 1);
    repeat (300) @(negedge clk);
    check("t2_no_valid", rx_valid, 0);
    check("t2_no_delivery", deliv_cnt - base_a, 0);

    // 3: bad stop bit followed by a break
    base_a = deliv_cnt;
    send_byte(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (1000) @(negedge clk);
    check("t3_valid", rx_valid, 1);
    check("t3_data", rx_data, 8'h3C);
    check("t3_ferr", frame_err, 1);
    check("t3_one_frame", deliv_cnt - base_a, 1);
    check("t3_break_idle", busy, 0);
    pulse_ready();
    rx_a = 1'b1;
    repeat (20) @(negedge clk);
    send_byte(1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_rec_valid", rx_valid, 1);
    check("t3_rec_data", rx_data, 8'h01);
    check("t3_rec_ferr", frame_err, 0);
    pulse_ready();
    repeat (20) @(negedge clk);

    // 4: even parity, good then bad
    send_byte(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t4_good_valid", p_valid, 1);
    check("t4_good_data", p_data, 8'h07);
    check("t4_good_perr", p_perr, 0);
    check("t4_good_ferr", p_ferr, 0);
    pulse_ready_p();
    repeat (20) @(negedge clk);
    send_byte(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t4_bad_valid", p_valid, 1);
    check("t4_bad_data", p_data, 8'h07);
    check("t4_bad_perr", p_perr, 1);
    pulse_ready_p();
    repeat (20) @(negedge clk);

    // 5a: back-to-back with no acceptance -> overrun
    base_a = ovr_cnt;
    send_byte(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
    send_byte(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t5_keep_data", rx_data, 8'h11);
    check("t5_keep_valid", rx_valid, 1);
    check("t5_ovr_pulse", ovr_cnt - base_a, 1);
    pulse_ready();
    repeat (20) @(negedge clk);

    // 5b: accept exactly on the second completion; frames are 1600 clocks apart
    base_a = ovr_cnt;
    base_b = vfall_cnt;
    ok = 1'b0;
    fork
      begin
        send_byte(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        send_byte(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
      end
      begin
        wn = 0;
        while (!rx_valid && wn < 2500) begin @(negedge clk); wn++; end
        ok = rx_valid;
        if (ok) begin
          repeat (10 * BIT - 1) @(negedge clk);
          pulse_ready();
        end
      end
    join
    check("t5b_first_seen", ok, 1);
    check("t5b_data", rx_data, 8'h22);
    check("t5b_valid", rx_valid, 1);
    check("t5b_no_drop", vfall_cnt - base_b, 0);
    check("t5b_no_ovr", ovr_cnt - base_a, 0);

    // 6: reset mid-frame while a byte is held
    hold_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) hold_bit(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    rx_a = 1'b1;
    @(negedge clk);
    check("t6_rst_data", rx_data, 0);
    check("t6_rst_valid", rx_valid, 0);
    check("t6_rst_ferr", frame_err, 0);
    check("t6_rst_perr", parity_err, 0);
    check("t6_rst_ovr", overrun, 0);
    check("t6_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send_byte(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t6_valid", rx_valid, 1);
    check("t6_data", rx_data, 8'h5A);
    check("t6_ferr", frame_err, 0);
    check("t6_perr", parity_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
